// File: rtl/z80_resp_pkg.sv
// Shared types and constants for the Z80 bus responder.
package z80_resp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      DRAIN,
      HOLD,
      INTA
   } state_t;

   typedef enum logic [1:0] {
      CYC_NONE,
      CYC_MEM,
      CYC_IO,
      CYC_INTA
   } cyc_t;

   // Largest legal minimum wait count; the wait counter is 4 bits wide.
   localparam int unsigned WAIT_MIN_MAX = 15;

   function automatic logic addr_match(input logic [15:0] addr, input logic [15:0] base,
                                       input logic [15:0] mask);
      return (addr & mask) == (base & mask);
   endfunction

endpackage

// File: rtl/z80_resp_decode.sv
// Combinational Z80 cycle-type and address-match decoder.
import z80_resp_pkg::*;

module z80_resp_decode #(
   parameter logic [15:0] MEM_BASE = 16'h8000,
   parameter logic [15:0] MEM_MASK = 16'hC000,
   parameter logic [7:0]  IO_BASE  = 8'h10,
   parameter logic [7:0]  IO_MASK  = 8'hF0
) (
   input  logic        m1,
   input  logic        mreq,
   input  logic        iorq,
   input  logic        rd,
   input  logic        wr,
   input  logic        rfsh,
   input  logic [15:0] ab,
   output cyc_t        cyc
);

   // Classify the current strobe pattern; INTA takes priority since it also carries iorq.
   always_comb begin
      cyc = CYC_NONE;
      if (m1 && iorq) begin
         cyc = CYC_INTA;
      end else if (mreq && (rd || wr) && !rfsh && addr_match(ab, MEM_BASE, MEM_MASK)) begin
         cyc = CYC_MEM;
      end else if (iorq && (rd || wr) && !m1 &&
                   addr_match({8'h00, ab[7:0]}, {8'h00, IO_BASE}, {8'h00, IO_MASK})) begin
         cyc = CYC_IO;
      end
   end

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 bus target: decodes mem/IO/INTA cycles, stretches them with WAIT until a
// single-beat backend handshake completes, and drives read data / the INT vector.
// Optional feature macro: Z80_RESP_INTA_EN (INTA decode, vector drive, INT pending flag).
import z80_resp_pkg::*;

module z80_bus_responder #(
   parameter logic [15:0] MEM_BASE = 16'h8000,
   parameter logic [15:0] MEM_MASK = 16'hC000,
   parameter logic [7:0]  IO_BASE  = 8'h10,
   parameter logic [7:0]  IO_MASK  = 8'hF0,
   parameter int unsigned WAIT_MIN = 0
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        m1,
   input  logic        mreq,
   input  logic        iorq,
   input  logic        rd,
   input  logic        wr,
   input  logic        rfsh,
   input  logic [15:0] ab,
   input  logic [7:0]  db_in,
   output logic [7:0]  db_out,
   output logic        db_oe,
   output logic        mwait,
   output logic        intr,
   output logic        be_req,
   output logic        be_we,
   output logic        be_io,
   output logic [15:0] be_addr,
   output logic [7:0]  be_wdata,
   input  logic        be_ack,
   input  logic [7:0]  be_rdata,
   input  logic        irq,
   input  logic [7:0]  int_vector
);

   localparam logic [3:0] WAIT_LOAD = (WAIT_MIN > WAIT_MIN_MAX) ? 4'(WAIT_MIN_MAX)
                                                                : 4'(WAIT_MIN);

   state_t     state;
   cyc_t       cyc;
   logic [3:0] cnt;
   logic       ack_seen;
   logic       rd_cycle;
   logic [7:0] rdata_lat;
   logic       got_ack;
   logic       done;

   z80_resp_decode #(
      .MEM_BASE (MEM_BASE),
      .MEM_MASK (MEM_MASK),
      .IO_BASE  (IO_BASE),
      .IO_MASK  (IO_MASK)
   ) u_decode (
      .m1   (m1),
      .mreq (mreq),
      .iorq (iorq),
      .rd   (rd),
      .wr   (wr),
      .rfsh (rfsh),
      .ab   (ab),
      .cyc  (cyc)
   );

   // The current-cycle ack counts so a zero-latency backend inserts no wait state.
   assign got_ack = ack_seen | be_ack;
   assign done    = got_ack && (cnt == 4'd0);
   assign mwait   = (state == REQ) && !done;

   // Cycle FSM, wait counter and registered backend request fields.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         ack_seen  <= 1'b0;
         rd_cycle  <= 1'b0;
         rdata_lat <= 8'h00;
         be_req    <= 1'b0;
         be_we     <= 1'b0;
         be_io     <= 1'b0;
         be_addr   <= 16'h0000;
         be_wdata  <= 8'h00;
      end else begin
         unique case (state)
            IDLE: begin
               if (cyc == CYC_MEM || cyc == CYC_IO) begin
                  be_req   <= 1'b1;
                  be_we    <= wr;
                  be_io    <= (cyc == CYC_IO);
                  be_addr  <= (cyc == CYC_IO) ? {8'h00, ab[7:0]} : ab;
                  be_wdata <= db_in;
                  cnt      <= WAIT_LOAD;
                  ack_seen <= 1'b0;
                  rd_cycle <= rd;
                  state    <= REQ;
               end
`ifdef Z80_RESP_INTA_EN
               else if (cyc == CYC_INTA) begin
                  state <= INTA;
               end
`endif
            end
            REQ: begin
               if (be_ack) begin
                  rdata_lat <= be_rdata;
                  ack_seen  <= 1'b1;
                  be_req    <= 1'b0;
               end
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end
               if (done) begin
                  state <= HOLD;
               end else if (!got_ack && !rd && !wr) begin
                  // CPU gave up before the backend answered; the request cannot be aborted.
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (be_ack) begin
                  be_req <= 1'b0;
                  state  <= IDLE;
               end
            end
            HOLD: begin
               if (!rd && !wr && !mreq && !iorq) begin
                  state <= IDLE;
               end
            end
            INTA: begin
               if (!iorq) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef Z80_RESP_INTA_EN
   logic flag;

   // INT pending flag: set by irq, cleared on INTA entry, set wins.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         flag <= 1'b0;
      end else if (irq) begin
         flag <= 1'b1;
      end else if (state == IDLE && cyc == CYC_INTA) begin
         flag <= 1'b0;
      end
   end

   assign intr = flag;
`else
   logic unused_inta;

   assign intr        = 1'b0;
   assign unused_inta = ^{irq, int_vector};
`endif

   // Read data / vector drive toward the pads.
   always_comb begin
      db_out = rdata_lat;
`ifdef Z80_RESP_INTA_EN
      if (state == INTA) begin
         db_out = int_vector;
      end else
`endif
      if (state == REQ && be_ack) begin
         db_out = be_rdata;
      end
      db_oe = (rd && rd_cycle && ((state == REQ && got_ack) || state == HOLD)) ||
              (state == INTA);
   end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed self-checking bench for z80_bus_responder (WAIT_MIN=0 and WAIT_MIN=2 instances).
module tb_z80_bus_responder;

`ifdef Z80_RESP_INTA_EN
   localparam logic INTA_EN = 1'b1;
`else
   localparam logic INTA_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        nreset;
   logic        m1, mreq, iorq, rd, wr, rfsh;
   logic [15:0] ab;
   logic [7:0]  db_in;
   logic        be_ack;
   logic [7:0]  be_rdata;
   logic        irq;
   logic [7:0]  int_vector;

   logic [7:0]  db_out, db_out2;
   logic        db_oe, db_oe2, mwait, mwait2, intr, intr2;
   logic        be_req, be_req2, be_we, be_we2, be_io, be_io2;
   logic [15:0] be_addr, be_addr2;
   logic [7:0]  be_wdata, be_wdata2;

   int n_checks = 0;
   int n_errors = 0;
   int w0, w2;

   always #5 clk = ~clk;

   z80_bus_responder u_dut (
      .clk(clk), .nreset(nreset), .m1(m1), .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr),
      .rfsh(rfsh), .ab(ab), .db_in(db_in), .db_out(db_out), .db_oe(db_oe), .mwait(mwait),
      .intr(intr), .be_req(be_req), .be_we(be_we), .be_io(be_io), .be_addr(be_addr),
      .be_wdata(be_wdata), .be_ack(be_ack), .be_rdata(be_rdata), .irq(irq),
      .int_vector(int_vector)
   );

   z80_bus_responder #(.WAIT_MIN(2)) u_dut_w2 (
      .clk(clk), .nreset(nreset), .m1(m1), .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr),
      .rfsh(rfsh), .ab(ab), .db_in(db_in), .db_out(db_out2), .db_oe(db_oe2), .mwait(mwait2),
      .intr(intr2), .be_req(be_req2), .be_we(be_we2), .be_io(be_io2), .be_addr(be_addr2),
      .be_wdata(be_wdata2), .be_ack(be_ack), .be_rdata(be_rdata), .irq(irq),
      .int_vector(int_vector)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   initial begin
      nreset = 1'b0;
      {m1, mreq, iorq, rd, wr, rfsh} = 6'b0;
      ab = 16'h0000; db_in = 8'h00; be_ack = 1'b0; be_rdata = 8'h00;
      irq = 1'b0; int_vector = 8'h00;

      // Reset state
      #3;
      check("rst_req", be_req, 0);
      check("rst_mwait", mwait, 0);
      check("rst_oe", db_oe, 0);
      check("rst_intr", intr, 0);
      check("rst_dout", db_out, 0);
      check("rst_addr", be_addr, 0);
      tick(); tick();
      nreset = 1'b1;
      tick();

      // Memory read 8123, ack in the first REQ clock
      ab = 16'h8123; mreq = 1; rd = 1;
      tick();
      be_ack = 1; be_rdata = 8'hA5;
      #1;
      check("t1_mwait", mwait, 0);
      check("t1_req", be_req, 1);
      check("t1_addr", be_addr, 16'h8123);
      check("t1_we", be_we, 0);
      check("t1_io", be_io, 0);
      check("t1_oe", db_oe, 1);
      check("t1_dout", db_out, 8'hA5);
      check("t1_w2_mwait", mwait2, 1);
      tick();
      be_ack = 0; be_rdata = 8'h00;
      #1;
      check("t1_req_drop", be_req, 0);
      check("t1_hold_dout", db_out, 8'hA5);
      check("t1_hold_oe", db_oe, 1);
      check("t1_hold_mwait", mwait, 0);
      rd = 0; mreq = 0;
      tick();
      check("t1_oe_off", db_oe, 0);
      idle(3);

      // Memory write 9000 <- 3C on the WAIT_MIN=2 instance, immediate ack
      ab = 16'h9000; db_in = 8'h3C; mreq = 1; wr = 1;
      tick();
      be_ack = 1; w2 = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (mwait2) w2++;
         if (i == 0) begin
            check("t2_wdata", be_wdata2, 8'h3C);
            check("t2_we", be_we2, 1);
            check("t2_req", be_req2, 1);
         end
         tick();
         be_ack = 0;
      end
      check("t2_wait_clocks", w2, 2);
      check("t2_req_drop", be_req2, 0);
      check("t2_oe", db_oe2, 0);
      wr = 0; mreq = 0; db_in = 8'h00;
      idle(2);

      // I/O read of port 12, ack 5 clocks after be_req
      ab = 16'h3412; iorq = 1; rd = 1;
      tick();
      w0 = 0; w2 = 0;
      for (int i = 0; i < 10; i++) begin
         be_ack = (i == 5); be_rdata = 8'h5A;
         #1;
         if (mwait) w0++;
         if (mwait2) w2++;
         if (i == 0) begin
            check("t3_io", be_io, 1);
            check("t3_addr", be_addr, 16'h0012);
            check("t3_req", be_req, 1);
         end
         if (i == 4) check("t3_req_held", be_req, 1);
         if (i == 5) begin
            check("t3_oe", db_oe, 1);
            check("t3_dout", db_out, 8'h5A);
            check("t3_mwait_end", mwait, 0);
         end
         tick();
      end
      be_ack = 0;
      check("t3_wait_clocks", w0, 5);
      check("t3_w2_wait_clocks", w2, 5);
      iorq = 0; rd = 0;
      idle(2);

      // Unmatched memory read, refresh, unmatched port: no response
      ab = 16'h0100; mreq = 1; rd = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t4_mem_req", be_req | be_req2, 0);
         check("t4_mem_mwait", mwait, 0);
         check("t4_mem_oe", db_oe, 0);
         tick();
      end
      mreq = 0; rd = 0;
      tick();
      ab = 16'h8000; mreq = 1; rfsh = 1; rd = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t4_rfsh_req", be_req | be_req2, 0);
         check("t4_rfsh_mwait", mwait, 0);
         check("t4_rfsh_oe", db_oe, 0);
         tick();
      end
      mreq = 0; rfsh = 0; rd = 0;
      tick();
      ab = 16'h1022; iorq = 1; rd = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("t4_port_req", be_req, 0);
         tick();
      end
      iorq = 0; rd = 0;
      idle(2);

      // irq pulse then INTA with vector FE
      irq = 1;
      tick();
      irq = 0;
      check("t5_intr_set", intr, INTA_EN);
      tick();
      check("t5_intr_held", intr, INTA_EN);
      m1 = 1; iorq = 1; int_vector = 8'hFE;
      #1;
      check("t5_intr_pre", intr, INTA_EN);
      tick();
      check("t5_intr_clr", intr, 0);
      check("t5_oe", db_oe, INTA_EN);
      check("t5_vec", db_out, INTA_EN ? 8'hFE : 8'h5A);
      check("t5_mwait", mwait, 0);
      check("t5_req", be_req, 0);
      tick();
      check("t5_oe_held", db_oe, INTA_EN);
      m1 = 0; iorq = 0;
      tick();
      check("t5_oe_off", db_oe, 0);
      // irq high on the INTA entry edge keeps the flag set
      irq = 1; m1 = 1; iorq = 1;
      tick();
      check("t5_set_wins", intr, INTA_EN);
      irq = 0; m1 = 0; iorq = 0;
      idle(2);

      // rd drops before the ack (ack at +4): DRAIN
      ab = 16'h8200; mreq = 1; rd = 1;
      tick();
      #1;
      check("t6_mwait", mwait, 1);
      check("t6_req", be_req, 1);
      rd = 0; mreq = 0;
      tick();
      for (int i = 1; i <= 4; i++) begin
         be_ack = (i == 4); be_rdata = 8'h77;
         #1;
         check("t6_drain_req", be_req, 1);
         check("t6_drain_mwait", mwait | mwait2, 0);
         check("t6_drain_oe", db_oe, 0);
         tick();
      end
      be_ack = 0;
      check("t6_req_drop", be_req, 0);
      check("t6_w2_req_drop", be_req2, 0);
      idle(2);

      // Reset asserted in REQ
      ab = 16'h8000; db_in = 8'h11; mreq = 1; wr = 1;
      tick();
      check("t7_req", be_req, 1);
      check("t7_wdata", be_wdata, 8'h11);
      nreset = 0;
      #1;
      check("t7_rst_req", be_req | be_req2, 0);
      check("t7_rst_mwait", mwait, 0);
      check("t7_rst_we", be_we, 0);
      check("t7_rst_addr", be_addr, 0);
      check("t7_rst_wdata", be_wdata, 0);
      check("t7_rst_oe", db_oe, 0);
      check("t7_rst_intr", intr, 0);
      mreq = 0; wr = 0;
      tick();
      nreset = 1;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/z80_bus_responder.md
# z80_bus_responder

Peripheral-side responder for the Z80 external bus, i.e. the target end of the cycles that the CPU pin control initiates. It decodes memory, I/O and interrupt-acknowledge cycles from the positive-logic pad signals (inverted outside this block, as on the CPU side) and hands selected cycles to a single-beat backend handshake. It stretches the bus cycle with WAIT until the backend completes, drives read data and the interrupt vector, and raises INT for a backend interrupt source. The block sits between the pad ring of a memory/IO device model or FPGA peripheral and its register file or RAM.

## Interface
- MEM_BASE, 16'h8000: memory decode base.
- MEM_MASK, 16'hC000: address bits compared for the memory match.
- IO_BASE, 8'h10: I/O decode base (port = ab[7:0]).
- IO_MASK, 8'hF0: port bits compared for the I/O match.
- WAIT_MIN, 0: minimum wait clocks per selected mem/IO cycle; legal range 0..15.
- clk in 1: CPU clock; all state on rising edge.
- nreset in 1: reset, asynchronous, active-low.
- m1, mreq, iorq, rd, wr, rfsh in 1 each: bus strobes, active-high.
- ab in 16: address bus.
- db_in in 8: data bus from pads.
- db_out out 8: data to pads.
- db_oe out 1: data pad output enable.
- mwait out 1: WAIT request, active-high.
- intr out 1: INT request, active-high.
- be_req out 1: backend request.
- be_we out 1: 1 = write.
- be_io out 1: 1 = I/O space.
- be_addr out 16: backend address (I/O: {8'h00, port}).
- be_wdata out 8: write data.
- be_ack in 1: backend completion, single-cycle pulse.
- be_rdata in 8: read data, valid with be_ack.
- irq in 1: backend interrupt source, level.
- int_vector in 8: vector returned on INTA.

## Operation
- Strobes are sampled on the rising clk edge.
- A cycle is "new" on the first edge where its strobe combination is seen while in IDLE:
  - Memory: mreq & (rd|wr) & ~rfsh & ((ab & MEM_MASK) == (MEM_BASE & MEM_MASK)).
  - I/O: iorq & (rd|wr) & ~m1 & port match.
  - INTA: m1 & iorq.
  - Refresh (mreq & rfsh) and unmatched cycles are ignored.
- States:
  - IDLE: on a new mem/IO cycle, register be_addr/be_we/be_io, register be_wdata = db_in, load cnt = WAIT_MIN, go to REQ. On INTA, go to INTA (only if the feature is compiled in).
  - REQ: be_req=1 until be_ack is seen. On be_ack: latch be_rdata, set ack_seen, drop be_req. Decrement cnt each clock while non-zero. When (ack_seen | be_ack) and cnt==0, go to HOLD. If rd and wr both drop before the ack, go to DRAIN.
  - DRAIN: be_req held until be_ack, then IDLE. Data is discarded; mwait=0, db_oe=0.
  - HOLD: waits until rd, wr, mreq and iorq are all low, then IDLE.
  - INTA: waits for iorq low, then IDLE.
- mwait is combinational: (state==REQ) & ~((ack_seen | be_ack) & cnt==0).
- Read data path:
  - db_oe = rd & matched read in REQ-after-ack or HOLD, or state INTA.
  - db_out = be_rdata in the ack cycle, else the latched value; int_vector in INTA.
- Handshake rules:
  - The backend must not ack without be_req.
  - Once raised, be_req stays high until be_ack, with no abort. Exception: reset.
- intr pending flag:
  - Set on any edge with irq=1.
  - Cleared on the INTA entry edge. Set wins over clear on the same edge.
  - intr = flag.

## Timing
- Reset values: all outputs 0, state IDLE, flag 0, cnt 0.
- Reset mid-cycle drops be_req immediately; the backend tolerates the abort.
- Memory cycle: mreq/rd are seen at the T2 rising edge. mwait is valid before the T2 falling edge, where the CPU samples WAIT.
- I/O cycle: iorq is seen at the T3 rising edge. mwait is valid before the T3 falling edge.
- With WAIT_MIN=0 and be_ack in the first REQ clock, no wait state is inserted.
- Wait clocks inserted = max(WAIT_MIN, ack latency in clocks from REQ entry).
- be_req rises one clock after detection. be_wdata is the db_in value captured at the detection edge.
- A new cycle is not accepted until HOLD or DRAIN has returned to IDLE. Back-to-back cycles therefore require the strobes to go idle for at least one sampled edge (always true on a Z80 bus).

## Configuration
- Z80_RESP_INTA_EN defined: INTA decode, the INTA state, int_vector drive, the intr pending flag and its clear are all present.
- Z80_RESP_INTA_EN undefined:
  - The INTA state and flag are removed and intr is tied to 0.
  - m1 & iorq is ignored.
  - int_vector and irq are unused.

## Structure
- Shared package z80_resp_pkg holds:
  - the state enum (IDLE, REQ, DRAIN, HOLD, INTA);
  - the cycle-type enum (CYC_NONE, CYC_MEM, CYC_IO, CYC_INTA);
  - the WAIT_MIN upper-limit constant (15).
- One sub-module, z80_resp_decode: a combinational cycle-type and address-match decoder parameterised by the base/mask values.
- The FSM, counter and datapath stay in the top module.

## Test plan
- Memory read at 16'h8123, WAIT_MIN=0, be_ack in the first REQ clock: no mwait; db_out=be_rdata=8'hA5 while rd is high; db_oe drops the clock after rd deasserts.
- Memory write at 16'h9000 of 8'h3C, WAIT_MIN=2, immediate ack: mwait high exactly 2 clocks; be_wdata=8'h3C, be_we=1.
- I/O read of port 8'h12, backend acks 5 clocks after be_req: mwait high 5 clocks; be_io=1, be_addr=16'h0012.
- Memory read at 16'h0100 and refresh at 16'h8000: be_req, mwait and db_oe stay 0.
- irq pulse, then an INTA cycle with int_vector=8'hFE: intr high until the INTA entry edge; db_out=8'hFE with db_oe while iorq is high. With the macro undefined, intr stays 0 and db_oe stays 0.
- rd drops in REQ before the ack (ack at +4): DRAIN with be_req held until the ack, mwait=0, db_oe=0. nreset asserted in REQ: all outputs 0 immediately.
